// File: rtl/hb_mac_seq.sv
`default_nettype none
// hb_mac_seq: issues NTAPS sample/coef reads per strobe and feeds registered products to an accumulator.
// Optional `HB_MAC_OVERRUN_EN adds a sticky overrun flag for strobes lost while busy.  Rev 1.0
module hb_mac_seq #(
  parameter int NTAPS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        strobe_in,
  output logic        rd_en,
  output logic [3:0]  tap_addr,
  input  logic [15:0] data_in,
  input  logic [14:0] coef_in,
  output logic        clear,
  output logic        enable_out,
  output logic [30:0] addend,
  output logic        strobe_out,
  output logic        busy,
  output logic        overrun
);

  localparam logic [3:0] LAST_TAP = 4'(NTAPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  tap_q, tap_d;

  logic        vld1_q, first1_q, last1_q;
  logic        vld2_q, first2_q, last2_q;
  logic        strobe_q;
  logic [30:0] addend_q;

  logic signed [30:0] data_ext, coef_ext, product;

  assign rd_en    = (state_q == RUN);
  assign tap_addr = tap_q;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
    end
  end

  // DRAIN waits until the final addend is on the bus before releasing busy.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    case (state_q)
      IDLE: begin
        if (strobe_in) begin
          state_d = RUN;
          tap_d   = '0;
        end
      end
      RUN: begin
        if (tap_q == LAST_TAP) begin
          state_d = DRAIN;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      DRAIN: begin
        if (last2_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_ext = {{15{data_in[15]}}, data_in};
  assign coef_ext = {{16{coef_in[14]}}, coef_in};
  assign product  = data_ext * coef_ext;

  // Stage 1 marks the cycle RAM data is valid; stage 2 is the addend cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld1_q   <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      vld2_q   <= 1'b0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
      strobe_q <= 1'b0;
      addend_q <= '0;
    end else begin
      vld1_q   <= rd_en;
      first1_q <= rd_en && (tap_q == 4'd0);
      last1_q  <= rd_en && (tap_q == LAST_TAP);
      vld2_q   <= vld1_q;
      first2_q <= first1_q;
      last2_q  <= last1_q;
      strobe_q <= last2_q;
      addend_q <= vld1_q ? product : '0;
    end
  end

  assign clear      = first2_q;
  assign enable_out = vld2_q;
  assign addend     = addend_q;
  assign strobe_out = strobe_q;

`ifdef HB_MAC_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (strobe_in && busy) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule
`default_nettype wire
